// File: rtl/execute_memory_stage_pkg.sv
// Shared types for the EX/MEM stage: word/register-select types and the dmem access FSM states.
package execute_memory_stage_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REGSEL_W = 5;
  localparam int unsigned CNT_W    = 32;

  typedef logic [DATA_W-1:0]   word_t;
  typedef logic [REGSEL_W-1:0] regbits_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } exmem_state_t;

endpackage

// File: rtl/execute_memory_stage_if.sv
// Signal bundle between ID/EX+ALU, the EX/MEM slot, dmem and MEM/WB.
// Statistics counters exist only when EXMEM_STATS_EN is defined.
interface execute_memory_stage_if;
  import execute_memory_stage_pkg::*;

  // Hazard unit
  logic     enable;
  logic     flush;
  logic     mem_stall;

  // EX-stage inputs
  logic     valid_EX;
  word_t    aluout_EX;
  word_t    storedata_EX;
  regbits_t final_wsel_EX;
  logic     RegWr_EX;
  logic     memtoReg_EX;
  logic     memWr_EX;
  logic     memRd_EX;
  logic     halt_EX;
  word_t    next_addr_EX;
  word_t    instr_EX;

  // MEM slot
  logic     valid_MEM;
  word_t    aluout_MEM;
  word_t    storedata_MEM;
  regbits_t final_wsel_MEM;
  logic     RegWr_MEM;
  logic     memtoReg_MEM;
  logic     memWr_MEM;
  logic     memRd_MEM;
  logic     halt_MEM;
  word_t    next_addr_MEM;
  word_t    instr_MEM;
  word_t    dmemload_MEM;

  // Data memory
  logic     dmemREN;
  logic     dmemWEN;
  word_t    dmemaddr;
  word_t    dmemstore;
  logic     dhit;
  word_t    dmemload;

`ifdef EXMEM_STATS_EN
  logic [CNT_W-1:0] load_cnt;
  logic [CNT_W-1:0] store_cnt;
  logic [CNT_W-1:0] stall_cnt;
`endif

`ifdef EXMEM_STATS_EN
  modport exmem (
    input  enable, flush, valid_EX, aluout_EX, storedata_EX, final_wsel_EX, RegWr_EX,
           memtoReg_EX, memWr_EX, memRd_EX, halt_EX, next_addr_EX, instr_EX, dhit, dmemload,
    output mem_stall, valid_MEM, aluout_MEM, storedata_MEM, final_wsel_MEM, RegWr_MEM,
           memtoReg_MEM, memWr_MEM, memRd_MEM, halt_MEM, next_addr_MEM, instr_MEM,
           dmemload_MEM, dmemREN, dmemWEN, dmemaddr, dmemstore, load_cnt, store_cnt, stall_cnt
  );
  modport tb (
    output enable, flush, valid_EX, aluout_EX, storedata_EX, final_wsel_EX, RegWr_EX,
           memtoReg_EX, memWr_EX, memRd_EX, halt_EX, next_addr_EX, instr_EX, dhit, dmemload,
    input  mem_stall, valid_MEM, aluout_MEM, storedata_MEM, final_wsel_MEM, RegWr_MEM,
           memtoReg_MEM, memWr_MEM, memRd_MEM, halt_MEM, next_addr_MEM, instr_MEM,
           dmemload_MEM, dmemREN, dmemWEN, dmemaddr, dmemstore, load_cnt, store_cnt, stall_cnt
  );
`else
  modport exmem (
    input  enable, flush, valid_EX, aluout_EX, storedata_EX, final_wsel_EX, RegWr_EX,
           memtoReg_EX, memWr_EX, memRd_EX, halt_EX, next_addr_EX, instr_EX, dhit, dmemload,
    output mem_stall, valid_MEM, aluout_MEM, storedata_MEM, final_wsel_MEM, RegWr_MEM,
           memtoReg_MEM, memWr_MEM, memRd_MEM, halt_MEM, next_addr_MEM, instr_MEM,
           dmemload_MEM, dmemREN, dmemWEN, dmemaddr, dmemstore
  );
  modport tb (
    output enable, flush, valid_EX, aluout_EX, storedata_EX, final_wsel_EX, RegWr_EX,
           memtoReg_EX, memWr_EX, memRd_EX, halt_EX, next_addr_EX, instr_EX, dhit, dmemload,
    input  mem_stall, valid_MEM, aluout_MEM, storedata_MEM, final_wsel_MEM, RegWr_MEM,
           memtoReg_MEM, memWr_MEM, memRd_MEM, halt_MEM, next_addr_MEM, instr_MEM,
           dmemload_MEM, dmemREN, dmemWEN, dmemaddr, dmemstore
  );
`endif

endinterface

// File: rtl/execute_memory_stage_dmem_fsm.sv
// Data-memory access sequencer for the MEM slot: IDLE -> ACCESS (request held until dhit) -> DONE.
// Requests are registered; they are set on the slot load that brings in a memory op.
module execute_memory_stage_dmem_fsm
  import execute_memory_stage_pkg::*;
(
  input  logic  clk_i,
  input  logic  rst_ni,       // synchronous, active-low
  input  logic  load_i,       // slot takes a new EX op this edge
  input  logic  flush_i,      // slot becomes a bubble this edge
  input  logic  access_i,     // incoming op is a valid memory op
  input  logic  rd_i,
  input  logic  wr_i,
  input  logic  dhit_i,
  input  word_t dmemload_i,
  output logic  ren_o,
  output logic  wen_o,
  output logic  stall_o,
  output word_t load_data_o,
  output logic  rd_done_o,
  output logic  wr_done_o
);

  exmem_state_t state_q;
  logic         ren_q;
  logic         wen_q;
  word_t        load_q;

  assign ren_o       = ren_q;
  assign wen_o       = wen_q;
  assign load_data_o = load_q;

  // A dhit in the issue cycle removes the stall entirely
  always_comb begin
    stall_o   = (state_q == ACCESS) & ~dhit_i;
    rd_done_o = (state_q == ACCESS) & dhit_i & ren_q;
    wr_done_o = (state_q == ACCESS) & dhit_i & wen_q;
  end

  // State, registered requests and load-data capture
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      load_q  <= '0;
    end else begin
      if (rd_done_o) begin
        load_q <= dmemload_i;
      end
      if (load_i) begin
        state_q <= access_i ? ACCESS : IDLE;
        // Write wins when both controls are set
        ren_q   <= access_i & rd_i & ~wr_i;
        wen_q   <= access_i & wr_i;
      end else if (flush_i || (state_q == ACCESS && dhit_i)) begin
        state_q <= flush_i ? IDLE : DONE;
        ren_q   <= 1'b0;
        wen_q   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/execute_memory_stage.sv
// EX/MEM pipeline register with data-memory access control and upstream stall.
// Optional feature macro: EXMEM_STATS_EN adds saturating load/store/stall counters.
module execute_memory_stage
  import execute_memory_stage_pkg::*;
(
  input  logic                    CLK,
  input  logic                    nRST,
  execute_memory_stage_if.exmem   bus
);

  logic  mem_stall;
  logic  hold;
  logic  take_flush;
  logic  take_load;
  logic  new_access;
  logic  ren;
  logic  wen;
  logic  rd_done;
  logic  wr_done;
  word_t load_data;

  // Slot changes only when memory is not busy and no halt has been latched
  always_comb begin
    hold       = mem_stall | bus.halt_MEM;
    take_flush = ~hold & bus.flush;
    take_load  = ~hold & ~bus.flush & bus.enable;
    new_access = bus.valid_EX & (bus.memRd_EX | bus.memWr_EX);
  end

  // MEM slot register: reset/flush clear it, load copies the EX fields
  always_ff @(posedge CLK) begin
    if (!nRST || take_flush) begin
      bus.valid_MEM      <= 1'b0;
      bus.aluout_MEM     <= '0;
      bus.storedata_MEM  <= '0;
      bus.final_wsel_MEM <= '0;
      bus.RegWr_MEM      <= 1'b0;
      bus.memtoReg_MEM   <= 1'b0;
      bus.memWr_MEM      <= 1'b0;
      bus.memRd_MEM      <= 1'b0;
      bus.halt_MEM       <= 1'b0;
      bus.next_addr_MEM  <= '0;
      bus.instr_MEM      <= '0;
    end else if (take_load) begin
      bus.valid_MEM      <= bus.valid_EX;
      bus.aluout_MEM     <= bus.aluout_EX;
      bus.storedata_MEM  <= bus.storedata_EX;
      bus.final_wsel_MEM <= bus.final_wsel_EX;
      bus.RegWr_MEM      <= bus.RegWr_EX;
      bus.memtoReg_MEM   <= bus.memtoReg_EX;
      bus.memWr_MEM      <= bus.memWr_EX;
      bus.memRd_MEM      <= bus.memRd_EX;
      bus.halt_MEM       <= bus.halt_EX;
      bus.next_addr_MEM  <= bus.next_addr_EX;
      bus.instr_MEM      <= bus.instr_EX;
    end
  end

  execute_memory_stage_dmem_fsm u_dmem_fsm (
    .clk_i       (CLK),
    .rst_ni      (nRST),
    .load_i      (take_load),
    .flush_i     (take_flush),
    .access_i    (new_access),
    .rd_i        (bus.memRd_EX),
    .wr_i        (bus.memWr_EX),
    .dhit_i      (bus.dhit),
    .dmemload_i  (bus.dmemload),
    .ren_o       (ren),
    .wen_o       (wen),
    .stall_o     (mem_stall),
    .load_data_o (load_data),
    .rd_done_o   (rd_done),
    .wr_done_o   (wr_done)
  );

  // Drive dmem and stall outputs from the slot and sequencer
  always_comb begin
    bus.mem_stall    = mem_stall;
    bus.dmemREN      = ren;
    bus.dmemWEN      = wen;
    bus.dmemaddr     = bus.aluout_MEM;
    bus.dmemstore    = bus.storedata_MEM;
    bus.dmemload_MEM = load_data;
  end

`ifdef EXMEM_STATS_EN
  // Saturating statistics counters
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      bus.load_cnt  <= '0;
      bus.store_cnt <= '0;
      bus.stall_cnt <= '0;
    end else begin
      if (rd_done && bus.load_cnt != '1) begin
        bus.load_cnt <= bus.load_cnt + CNT_W'(1);
      end
      if (wr_done && bus.store_cnt != '1) begin
        bus.store_cnt <= bus.store_cnt + CNT_W'(1);
      end
      if (mem_stall && bus.stall_cnt != '1) begin
        bus.stall_cnt <= bus.stall_cnt + CNT_W'(1);
      end
    end
  end
`else
  logic unused_done;
  assign unused_done = rd_done ^ wr_done;
`endif

endmodule

// File: tb/tb_execute_memory_stage.sv
// Scoreboard bench for execute_memory_stage: a transaction-level model predicts every cycle's
// outputs, which a negedge monitor compares; directed scenarios add explicit spot checks.
module tb_execute_memory_stage;
  import execute_memory_stage_pkg::*;

  logic CLK = 1'b0;
  logic nRST;

  execute_memory_stage_if bus ();

  execute_memory_stage dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic     valid;
    word_t    alu;
    word_t    sd;
    regbits_t ws;
    logic     rw, m2r, mw, mr, halt;
    word_t    na;
    word_t    ins;
  } slot_t;

  typedef struct packed {
    slot_t s;
    word_t ld;
    word_t addr;
    word_t st;
    logic  ren, wen, stall;
  } obs_t;

  typedef struct packed {
    logic [CNT_W-1:0] l, s, t;
  } cnt_t;

  typedef struct packed {
    logic  rst_n, enable, flush;
    slot_t ex;
    logic  dhit;
    word_t dload;
  } drv_t;

  // Reference model: the instruction in MEM, whether its access is outstanding, last load data
  slot_t       m_slot;
  logic        m_pend;
  word_t       m_ld;
  int unsigned m_nl, m_ns, m_nt;

  obs_t obs_q[$];
  cnt_t cnt_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic word_t sat_inc(input int unsigned v);
    return (v == 32'hFFFF_FFFF) ? v : v + 1;
  endfunction

  task automatic model_reset();
    m_slot = '0;
    m_pend = 1'b0;
    m_ld   = '0;
    m_nl   = 0;
    m_ns   = 0;
    m_nt   = 0;
  endtask

  function automatic obs_t model_obs(input drv_t d);
    obs_t o;
    o.s     = m_slot;
    o.ld    = m_ld;
    o.addr  = m_slot.alu;
    o.st    = m_slot.sd;
    o.ren   = m_pend & m_slot.mr & ~m_slot.mw;
    o.wen   = m_pend & m_slot.mw;
    o.stall = m_pend & ~d.dhit;
    return o;
  endfunction

  // What the rising edge does, stated as instruction-level rules
  task automatic model_edge(input drv_t d);
    logic busy;
    busy = m_pend & ~d.dhit;
    if (!d.rst_n) begin
      model_reset();
      return;
    end
    if (busy) m_nt = sat_inc(m_nt);
    if (m_pend && d.dhit) begin
      if (m_slot.mw) begin
        m_ns = sat_inc(m_ns);
      end else begin
        m_ld = d.dload;
        m_nl = sat_inc(m_nl);
      end
      m_pend = 1'b0;
    end
    if (!busy && !m_slot.halt) begin
      if (d.flush) begin
        m_slot = '0;
        m_pend = 1'b0;
      end else if (d.enable) begin
        m_slot = d.ex;
        m_pend = d.ex.valid & (d.ex.mr | d.ex.mw);
      end
    end
  endtask

  task automatic apply(input drv_t d);
    nRST              = d.rst_n;
    bus.enable        = d.enable;
    bus.flush         = d.flush;
    bus.valid_EX      = d.ex.valid;
    bus.aluout_EX     = d.ex.alu;
    bus.storedata_EX  = d.ex.sd;
    bus.final_wsel_EX = d.ex.ws;
    bus.RegWr_EX      = d.ex.rw;
    bus.memtoReg_EX   = d.ex.m2r;
    bus.memWr_EX      = d.ex.mw;
    bus.memRd_EX      = d.ex.mr;
    bus.halt_EX       = d.ex.halt;
    bus.next_addr_EX  = d.ex.na;
    bus.instr_EX      = d.ex.ins;
    bus.dhit          = d.dhit;
    bus.dmemload      = d.dload;
  endtask

  // One cycle: drive after the edge, record the expectation, advance the model, return at negedge
  task automatic step(input drv_t d);
    @(posedge CLK);
    #1;
    apply(d);
    obs_q.push_back(model_obs(d));
    cnt_q.push_back({CNT_W'(m_nl), CNT_W'(m_ns), CNT_W'(m_nt)});
    model_edge(d);
    @(negedge CLK);
  endtask

  function automatic drv_t nop();
    drv_t d;
    d       = '0;
    d.rst_n = 1'b1;
    return d;
  endfunction

  function automatic drv_t rand_drv();
    drv_t d;
    d.rst_n     = ($urandom_range(0, 39) != 0);
    d.enable    = ($urandom_range(0, 3) != 0);
    d.flush     = ($urandom_range(0, 7) == 0);
    d.ex.valid  = ($urandom_range(0, 3) != 0);
    d.ex.alu    = $urandom;
    d.ex.sd     = $urandom;
    d.ex.ws     = regbits_t'($urandom);
    d.ex.rw     = $urandom_range(0, 1) == 1;
    d.ex.m2r    = $urandom_range(0, 1) == 1;
    d.ex.mw     = ($urandom_range(0, 3) == 0);
    d.ex.mr     = ($urandom_range(0, 2) == 0);
    d.ex.halt   = ($urandom_range(0, 31) == 0);
    d.ex.na     = $urandom;
    d.ex.ins    = $urandom;
    d.dhit      = ($urandom_range(0, 2) == 0);
    d.dload     = $urandom;
    return d;
  endfunction

  // Monitor: every cycle the DUT presents a full output vector, compared against the queue head
  always @(negedge CLK) begin
    obs_t e, a;
    cnt_t ec;
    if (obs_q.size() > 0) begin
      e           = obs_q.pop_front();
      ec          = cnt_q.pop_front();
      a.s.valid   = bus.valid_MEM;
      a.s.alu     = bus.aluout_MEM;
      a.s.sd      = bus.storedata_MEM;
      a.s.ws      = bus.final_wsel_MEM;
      a.s.rw      = bus.RegWr_MEM;
      a.s.m2r     = bus.memtoReg_MEM;
      a.s.mw      = bus.memWr_MEM;
      a.s.mr      = bus.memRd_MEM;
      a.s.halt    = bus.halt_MEM;
      a.s.na      = bus.next_addr_MEM;
      a.s.ins     = bus.instr_MEM;
      a.ld        = bus.dmemload_MEM;
      a.addr      = bus.dmemaddr;
      a.st        = bus.dmemstore;
      a.ren       = bus.dmemREN;
      a.wen       = bus.dmemWEN;
      a.stall     = bus.mem_stall;
      check("cycle_outputs", 256'(a), 256'(e));
`ifdef EXMEM_STATS_EN
      check("counters", 256'({bus.load_cnt, bus.store_cnt, bus.stall_cnt}), 256'(ec));
`endif
    end
  end

  initial begin
    drv_t d;
    model_reset();
    d       = '1;
    d.rst_n = 1'b0;
    apply(d);

    // Reset with every EX input high
    step(d);
    check("rst_valid_MEM", 256'(bus.valid_MEM), 256'(0));
    check("rst_aluout_MEM", 256'(bus.aluout_MEM), 256'(0));
    check("rst_halt_MEM", 256'(bus.halt_MEM), 256'(0));
    check("rst_requests", 256'({bus.dmemREN, bus.dmemWEN, bus.mem_stall}), 256'(0));

    // Plain ALU op
    d = nop(); d.enable = 1; d.ex.valid = 1; d.ex.alu = 32'h0000_1234; d.ex.rw = 1;
    step(d);
    step(nop());
    check("alu_aluout_MEM", 256'(bus.aluout_MEM), 256'(32'h1234));
    check("alu_RegWr_MEM", 256'(bus.RegWr_MEM), 256'(1));
    check("alu_no_request", 256'({bus.dmemREN, bus.dmemWEN}), 256'(0));

    // Load with dhit after three stall cycles; EX keeps offering new work meanwhile
    d = nop(); d.enable = 1; d.ex.valid = 1; d.ex.mr = 1; d.ex.m2r = 1; d.ex.rw = 1;
    d.ex.alu = 32'h100; d.ex.ws = 5'd3;
    step(d);
    for (int i = 0; i < 3; i++) begin
      d = nop(); d.enable = 1; d.ex.valid = 1; d.ex.alu = 32'h999 + i;
      step(d);
      check("load_ren", 256'(bus.dmemREN), 256'(1));
      check("load_stall", 256'(bus.mem_stall), 256'(1));
      check("load_slot_held", 256'(bus.aluout_MEM), 256'(32'h100));
    end
    d = nop(); d.dhit = 1; d.dload = 32'hDEAD_BEEF;
    step(d);
    check("load_hit_nostall", 256'({bus.dmemREN, bus.mem_stall}), 256'(2'b10));
    d = nop(); d.dhit = 1; d.dload = 32'h1111_2222;
    step(d);
    check("load_data", 256'(bus.dmemload_MEM), 256'(32'hDEAD_BEEF));
    check("load_done_req", 256'({bus.dmemREN, bus.mem_stall}), 256'(0));
    step(nop());
    check("done_no_reissue", 256'(bus.dmemREN), 256'(0));
    check("done_dhit_ignored", 256'(bus.dmemload_MEM), 256'(32'hDEAD_BEEF));

    // Store completing in its issue cycle
    d = nop(); d.enable = 1; d.ex.valid = 1; d.ex.mw = 1; d.ex.sd = 32'hCAFE; d.ex.alu = 32'h200;
    step(d);
    d = nop(); d.dhit = 1;
    step(d);
    check("store_wen", 256'({bus.dmemWEN, bus.dmemREN, bus.mem_stall}), 256'(3'b100));
    check("store_data", 256'(bus.dmemstore), 256'(32'hCAFE));
    step(nop());
    check("store_wen_drop", 256'(bus.dmemWEN), 256'(0));

    // Flush is ignored while stalled, honoured afterwards
    d = nop(); d.enable = 1; d.ex.valid = 1; d.ex.mw = 1; d.ex.mr = 1; d.ex.alu = 32'h300;
    d.ex.sd = 32'h55;
    step(d);
    d = nop(); d.flush = 1;
    step(d);
    check("flush_stall_wen", 256'({bus.dmemWEN, bus.dmemREN, bus.mem_stall}), 256'(3'b101));
    step(d);
    check("flush_ignored", 256'(bus.valid_MEM), 256'(1));
    d = nop(); d.dhit = 1;
    step(d);
    d = nop(); d.flush = 1;
    step(d);
    step(nop());
    check("flush_valid", 256'(bus.valid_MEM), 256'(0));
    check("flush_fields", 256'({bus.aluout_MEM, bus.storedata_MEM, bus.memWr_MEM}), 256'(0));

    // Halt freezes the slot until reset
    d = nop(); d.enable = 1; d.ex.valid = 1; d.ex.halt = 1; d.ex.mr = 1; d.ex.alu = 32'h400;
    step(d);
    d = nop(); d.dhit = 1; d.dload = 32'h4444;
    step(d);
    d = nop(); d.enable = 1; d.ex.valid = 1; d.ex.alu = 32'h500; d.ex.rw = 1;
    step(d);
    step(d);
    check("halt_sticky", 256'({bus.halt_MEM, bus.aluout_MEM}), 256'({1'b1, 32'h400}));

    // Reset in the middle of an access
    d = nop(); d.rst_n = 0;
    step(d);
    d = nop(); d.enable = 1; d.ex.valid = 1; d.ex.mr = 1; d.ex.alu = 32'h600;
    step(d);
    step(nop());
    check("rst_mid_ren", 256'({bus.dmemREN, bus.mem_stall}), 256'(2'b11));
    d = nop(); d.rst_n = 0;
    step(d);
    step(nop());
    check("rst_mid_after", 256'({bus.dmemREN, bus.mem_stall, bus.valid_MEM}), 256'(0));
`ifdef EXMEM_STATS_EN
    check("rst_counters", 256'({bus.load_cnt, bus.store_cnt, bus.stall_cnt}), 256'(0));
`endif

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(rand_drv());
    end

    @(posedge CLK);
    #1;
    check("scoreboard_drained", 256'(obs_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
